spi_xfer_seq: RTL
=================

SPI_XFER_SEQ -- requirements
Module: spi_xfer_seq

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, TX/RX FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter SPI_SEL_DEF, default 0, reset value of the SPI device select field.
REQ-003 clk  in  1  sole clock, all state on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 reg_addr  in  3  host register address.
REQ-006 reg_data_in  in  8  host write data.
REQ-007 reg_data_out  out  8  host read data, combinational from reg_addr.
REQ-008 reg_read / reg_write  in  1 each  host one-cycle strobes.
REQ-009 interrupt  out  1  done AND int-enable.
REQ-010 spi_reg_addr  out  3  SPI controller register address.
REQ-011 spi_reg_data_out  out  8  byte driven to SPI controller.
REQ-012 spi_reg_data_in  in  8  SPI controller read data, valid in the same cycle as spi_reg_read.
REQ-013 spi_reg_sel  out  2  device select, from control register.
REQ-014 spi_reg_read / spi_reg_write  out  1 each  one-cycle strobes to the SPI controller, never both high.
REQ-015 spi_interrupt  in  1  byte-complete from the SPI controller, cleared by it the cycle after the next accepted write or end-read.

Function
REQ-016 Host map: addr0 write pushes TX FIFO, read pops RX FIFO; addr1 write sets len (bytes-1, 1..256 bytes); addr2 write ctrl {bit0 go, bits2:1 sel, bit3 ien}; addr2 read status {0,0,ovf,done,rx_empty,rx_full,tx_full,busy}; addr3 write bit0 clears done, bit1 clears ovf; other reads return 0.
REQ-017 FSM states SHALL be IDLE, START, WAIT, MID_RD, SEND, FIN.
REQ-018 IDLE: go with busy=0 loads remain<=len, clears done, goes START; go while busy SHALL be ignored.
REQ-019 START: once TX non-empty, assert spi_reg_write addr0 with TX head, pop TX, go WAIT.
REQ-020 WAIT: on spi_interrupt high, go FIN if remain==0, else MID_RD.
REQ-021 MID_RD: once RX not full, assert spi_reg_read addr1, push spi_reg_data_in to RX, go SEND.
REQ-022 SEND: once TX non-empty, assert spi_reg_write addr1 with TX head, pop TX, decrement remain, go WAIT.
REQ-023 FIN: once RX not full, assert spi_reg_read addr0 (ends transaction), push RX, set done, go IDLE.
REQ-024 Minimum per-byte overhead SHALL be 2 cycles after spi_interrupt is first seen (MID_RD then SEND).
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 Host push to full TX SHALL be dropped and set ovf; pop of empty RX SHALL return 0x00 and leave state unchanged.
REQ-027 Simultaneous host push and sequencer pop on one FIFO SHALL both take effect; count unchanged.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-029 Writes to len/sel while busy SHALL be ignored; ien is writable at any time.

Reset
REQ-030 On reset: state IDLE, FIFOs empty, remain 0, len 0, sel SPI_SEL_DEF, ien 0, done 0, ovf 0, all spi_* strobes 0, interrupt 0.
REQ-031 Reset mid-transfer SHALL abandon the transfer with no further SPI strobes; SPI controller shares the reset.

Configuration
REQ-032 Macro SPI_XFER_SEQ_RXFIFO_EN defined: RX FIFO present as above.
REQ-033 Macro undefined: no RX FIFO; MID_RD/FIN never wait on RX space, received bytes discarded, addr0 read returns 0, rx_empty reads 1, rx_full reads 0.

Structure
REQ-034 Shared package spi_seq_pkg SHALL hold the FSM state enum, host register address constants and status bit positions.
REQ-035 One sub-module seq_fifo (parameterised depth/width, push/pop/full/empty/count) SHALL be instantiated for TX and, when enabled, RX.

Verification
REQ-036 len=0, push 0xA5, go -> one write addr0 0xA5, after spi_interrupt one read addr0, RX holds rx byte, done=1, busy=0.
REQ-037 len=3, push 0x01..0x04, go -> writes addr0,1,1,1 with 0x01..0x04, reads addr1 x3 then addr0, RX pops 4 bytes in order.
REQ-038 len=9, FIFO_DEPTH=8, host refills TX after 4 bytes -> SEND stalls while TX empty, all 10 bytes sent in order, no strobe while stalled.
REQ-039 Push 9 bytes into empty TX (depth 8) -> ninth dropped, ovf=1; addr3 write 0x02 -> ovf=0.
REQ-040 ien=1, transfer completes -> interrupt=1; addr3 write 0x01 -> interrupt=0 next cycle.
REQ-041 Reset asserted in WAIT of byte 2 of 4 -> next cycle state IDLE, busy=0, FIFOs empty, no further spi strobes.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// -----------------------------------------------------------------------------
// spi_seq_pkg
// Shared definitions for the SPI transfer sequencer: sequencer state encoding,
// host register map, SPI controller register addresses, control/clear/status
// bit positions and a status-byte packing helper.
// -----------------------------------------------------------------------------
package spi_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_MID_RD = 3'd3,
    ST_SEND   = 3'd4,
    ST_FIN    = 3'd5
  } seq_state_e;

  // Host-side register addresses
  localparam logic [2:0] HADDR_DATA = 3'd0;
  localparam logic [2:0] HADDR_LEN  = 3'd1;
  localparam logic [2:0] HADDR_CTRL = 3'd2;
  localparam logic [2:0] HADDR_CLR  = 3'd3;

  // SPI controller register addresses: addr0 opens/closes a transaction,
  // addr1 continues it.
  localparam logic [2:0] SPI_ADDR_EDGE = 3'd0;
  localparam logic [2:0] SPI_ADDR_MID  = 3'd1;

  // Control register bits
  localparam int CTRL_GO      = 0;
  localparam int CTRL_SEL_LSB = 1;
  localparam int CTRL_IEN     = 3;

  // Clear register bits
  localparam int CLR_DONE = 0;
  localparam int CLR_OVF  = 1;

  // Status register bits
  localparam int STAT_BUSY     = 0;
  localparam int STAT_TX_FULL  = 1;
  localparam int STAT_RX_FULL  = 2;
  localparam int STAT_RX_EMPTY = 3;
  localparam int STAT_DONE     = 4;
  localparam int STAT_OVF      = 5;

  function automatic logic [7:0] pack_status(
    input logic ovf,
    input logic done,
    input logic rx_empty,
    input logic rx_full,
    input logic tx_full,
    input logic busy
  );
    logic [7:0] s;
    s                = 8'h00;
    s[STAT_OVF]      = ovf;
    s[STAT_DONE]     = done;
    s[STAT_RX_EMPTY] = rx_empty;
    s[STAT_RX_FULL]  = rx_full;
    s[STAT_TX_FULL]  = tx_full;
    s[STAT_BUSY]     = busy;
    return s;
  endfunction

endpackage

// File: rtl/spi_xfer_seq_fifo.sv
// -----------------------------------------------------------------------------
// seq_fifo
// Synchronous single-clock FIFO used for the sequencer TX and RX byte queues.
// Show-ahead: pop_data_o always presents the head entry.
//
// Parameters : DEPTH  - entries, power of two (2..16)
//              DATA_W - entry width
// Ports      : clk, reset       - clock, synchronous active-high reset
//              push_i/push_data_i - write strobe and data
//              pop_i            - read strobe (ignored when empty)
//              pop_data_o       - head entry
//              full_o/empty_o   - occupancy flags
//              count_o          - occupancy, $clog2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module seq_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] pop_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CW-1:0]     count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok;
  logic              pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;

  // A push into a full FIFO still lands when a pop frees the head slot in the
  // same cycle; the occupancy then stays where it was.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Pointers are AW bits wide, so the +1 wraps modulo DEPTH by itself.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/spi_xfer_seq.sv
// -----------------------------------------------------------------------------
// spi_xfer_seq
// Host-programmable SPI transfer sequencer. The host queues bytes in a TX
// FIFO, programs a length (bytes-1) and sets go; the sequencer then drives an
// SPI byte controller: first byte written at addr0, each following byte is
// preceded by a read of the previous received byte at addr1 and written at
// addr1, and the transaction is closed by a read at addr0. Received bytes go
// to an RX FIFO when present.
//
// Build option: define SPI_XFER_SEQ_RXFIFO_EN to include the RX FIFO. Without
// it received bytes are discarded, addr0 reads return 0, rx_empty reads 1 and
// rx_full reads 0.
//
// Parameters : FIFO_DEPTH  - TX/RX FIFO entries (power of two, 2..16)
//              SPI_SEL_DEF - reset value of the device select field
// Ports      : clk, reset                 - clock, sync active-high reset
//              reg_addr/reg_data_in       - host address and write data
//              reg_read/reg_write         - host one-cycle strobes
//              reg_data_out               - host read data (combinational)
//              interrupt                  - done AND interrupt enable
//              spi_reg_addr/_data_out     - SPI controller address/data
//              spi_reg_data_in            - SPI controller read data
//              spi_reg_sel                - device select
//              spi_reg_read/_write        - SPI controller strobes
//              spi_interrupt              - SPI byte complete
// -----------------------------------------------------------------------------
module spi_xfer_seq
  import spi_seq_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 8,
  parameter logic [1:0] SPI_SEL_DEF = 2'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] reg_addr,
  input  logic [7:0] reg_data_in,
  output logic [7:0] reg_data_out,
  input  logic       reg_read,
  input  logic       reg_write,
  output logic       interrupt,
  output logic [2:0] spi_reg_addr,
  output logic [7:0] spi_reg_data_out,
  input  logic [7:0] spi_reg_data_in,
  output logic [1:0] spi_reg_sel,
  output logic       spi_reg_read,
  output logic       spi_reg_write,
  input  logic       spi_interrupt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  seq_state_e state_q, state_d;
  logic [7:0] remain_q, remain_d;
  logic [7:0] len_q, len_d;
  logic [1:0] sel_q, sel_d;
  logic       ien_q, ien_d;
  logic       done_q, done_d;
  logic       ovf_q, ovf_d;

  logic       host_wr_data, host_wr_len, host_wr_ctrl, host_wr_clr;
  logic       host_rd_data;
  logic       busy, go;

  logic       tx_pop, tx_full, tx_empty;
  logic [7:0] tx_head;
  logic [CW-1:0] tx_count;

  logic       rx_push, rx_full, rx_empty;
  logic [7:0] rx_head;

  logic       done_set;
  logic       spi_wr, spi_rd;
  logic       unused_ok;

  // Host register decode
  assign host_wr_data = reg_write && (reg_addr == HADDR_DATA);
  assign host_wr_len  = reg_write && (reg_addr == HADDR_LEN);
  assign host_wr_ctrl = reg_write && (reg_addr == HADDR_CTRL);
  assign host_wr_clr  = reg_write && (reg_addr == HADDR_CLR);
  assign host_rd_data = reg_read  && (reg_addr == HADDR_DATA);

  assign busy = (state_q != ST_IDLE);
  assign go   = host_wr_ctrl && reg_data_in[CTRL_GO] && !busy;

  seq_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_tx_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (host_wr_data),
    .push_data_i (reg_data_in),
    .pop_i       (tx_pop),
    .pop_data_o  (tx_head),
    .full_o      (tx_full),
    .empty_o     (tx_empty),
    .count_o     (tx_count)
  );

`ifdef SPI_XFER_SEQ_RXFIFO_EN
  logic [CW-1:0] rx_count;

  seq_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_rx_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (rx_push),
    .push_data_i (spi_reg_data_in),
    .pop_i       (host_rd_data),
    .pop_data_o  (rx_head),
    .full_o      (rx_full),
    .empty_o     (rx_empty),
    .count_o     (rx_count)
  );

  assign unused_ok = ^{tx_count, rx_count};
`else
  // No receive queue: the sequencer never waits for RX space and the bytes
  // returned by the controller are dropped.
  assign rx_full   = 1'b0;
  assign rx_empty  = 1'b1;
  assign rx_head   = 8'h00;
  assign unused_ok = ^{tx_count, rx_push, host_rd_data, spi_reg_data_in};
`endif

  // Sequencer next state and SPI controller accesses
  always_comb begin
    state_d          = state_q;
    remain_d         = remain_q;
    done_set         = 1'b0;
    tx_pop           = 1'b0;
    rx_push          = 1'b0;
    spi_wr           = 1'b0;
    spi_rd           = 1'b0;
    spi_reg_addr     = SPI_ADDR_EDGE;
    spi_reg_data_out = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          remain_d = len_q;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (!tx_empty) begin
          spi_wr           = 1'b1;
          spi_reg_addr     = SPI_ADDR_EDGE;
          spi_reg_data_out = tx_head;
          tx_pop           = 1'b1;
          state_d          = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (spi_interrupt) state_d = (remain_q == 8'd0) ? ST_FIN : ST_MID_RD;
      end
      ST_MID_RD: begin
        if (!rx_full) begin
          spi_rd       = 1'b1;
          spi_reg_addr = SPI_ADDR_MID;
          rx_push      = 1'b1;
          state_d      = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!tx_empty) begin
          spi_wr           = 1'b1;
          spi_reg_addr     = SPI_ADDR_MID;
          spi_reg_data_out = tx_head;
          tx_pop           = 1'b1;
          remain_d         = remain_q - 8'd1;
          state_d          = ST_WAIT;
        end
      end
      ST_FIN: begin
        if (!rx_full) begin
          spi_rd       = 1'b1;
          spi_reg_addr = SPI_ADDR_EDGE;
          rx_push      = 1'b1;
          done_set     = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Host-visible register updates. Length and select are frozen while a
  // transfer runs; the interrupt enable may change at any time.
  always_comb begin
    len_d  = len_q;
    sel_d  = sel_q;
    ien_d  = ien_q;
    done_d = done_q;
    ovf_d  = ovf_q;
    if (host_wr_len && !busy) len_d = reg_data_in;
    if (host_wr_ctrl) begin
      ien_d = reg_data_in[CTRL_IEN];
      if (!busy) sel_d = reg_data_in[CTRL_SEL_LSB +: 2];
    end
    // A push is only lost when the FIFO is full and not popped this cycle.
    if (host_wr_data && tx_full && !tx_pop) ovf_d = 1'b1;
    else if (host_wr_clr && reg_data_in[CLR_OVF]) ovf_d = 1'b0;
    if (done_set) done_d = 1'b1;
    else if (go || (host_wr_clr && reg_data_in[CLR_DONE])) done_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      remain_q <= 8'd0;
      len_q    <= 8'd0;
      sel_q    <= SPI_SEL_DEF;
      ien_q    <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      len_q    <= len_d;
      sel_q    <= sel_d;
      ien_q    <= ien_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  // Strobes are masked while reset is held so an interrupted transfer cannot
  // issue one last access in the reset cycle.
  assign spi_reg_write = spi_wr && !reset;
  assign spi_reg_read  = spi_rd && !reset;
  assign spi_reg_sel   = sel_q;
  assign interrupt     = done_q && ien_q;

  always_comb begin
    reg_data_out = 8'h00;
    case (reg_addr)
      HADDR_DATA: reg_data_out = rx_empty ? 8'h00 : rx_head;
      HADDR_CTRL: reg_data_out = pack_status(ovf_q, done_q, rx_empty, rx_full,
                                             tx_full, busy);
      default:    reg_data_out = 8'h00;
    endcase
  end

endmodule
